// File: rtl/waterfall_writer.sv
`default_nettype none
// ============================================================================
//  Module   : waterfall_writer
//  Purpose  : Streams spectrum bins (one byte per pixel) into a WIDTH x HEIGHT
//             framebuffer RAM row by row, wrapping back to row 0 after the
//             last row.  A display port can read any framebuffer byte.  Reads
//             take priority over incoming samples and complete in 3 cycles.
//
//  Ports    : clk, reset_n     - clock, asynchronous active-low reset
//             s_data/s_valid/s_ready   - pixel input stream (valid/ready)
//             rd_req/rd_addr/rd_ready  - display read request
//             rd_data/rd_valid         - read result, one-cycle pulse
//             ram_addr/ram_wdata/ram_wen/ram_rdata - framebuffer RAM port
//             line_done/last_row       - row-completed pulse and its index
//             busy                     - frame clear in progress
//
//  Macro    : FRAME_CLEAR_EN - when defined, every reset is followed by a
//             clear pass writing 0 to the whole framebuffer (busy high).
//             Undefined: no clear pass, busy tied low.
//
//  Revision : 1.0 - initial release
// ============================================================================
module waterfall_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  s_data,
    input  logic        s_valid,
    output logic        s_ready,
    input  logic        rd_req,
    input  logic [16:0] rd_addr,
    output logic        rd_ready,
    output logic [7:0]  rd_data,
    output logic        rd_valid,
    output logic [16:0] ram_addr,
    output logic [7:0]  ram_wdata,
    output logic        ram_wen,
    input  logic [7:0]  ram_rdata,
    output logic        line_done,
    output logic [7:0]  last_row,
    output logic        busy
);

    localparam logic [16:0] c_WIDTH    = 17'(WIDTH);
    localparam logic [16:0] c_COL_LAST = 17'(WIDTH - 1);
    localparam logic [7:0]  c_ROW_LAST = 8'(HEIGHT - 1);

    localparam logic [1:0] c_ST_IDLE    = 2'd1;
    localparam logic [1:0] c_ST_RD_ADDR = 2'd2;
    localparam logic [1:0] c_ST_RD_HOLD = 2'd3;
`ifdef FRAME_CLEAR_EN
    localparam logic [1:0]  c_ST_CLEAR    = 2'd0;
    localparam logic [1:0]  c_ST_RESET    = c_ST_CLEAR;
    localparam logic [16:0] c_PIX_LAST    = 17'(WIDTH * HEIGHT - 1);
`else
    localparam logic [1:0]  c_ST_RESET    = c_ST_IDLE;
`endif

    logic [1:0]  r_state;
    logic [16:0] r_wr_col;
    logic [7:0]  r_wr_row;
    logic [16:0] r_row_base;   // wr_row * WIDTH, kept by accumulation
`ifdef FRAME_CLEAR_EN
    logic [16:0] r_clr_cnt;
`endif

    assign rd_ready = (r_state == c_ST_IDLE);
    assign s_ready  = (r_state == c_ST_IDLE) && !rd_req;

`ifdef FRAME_CLEAR_EN
    assign busy = (r_state == c_ST_CLEAR);
`else
    assign busy = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state    <= c_ST_RESET;
            ram_addr   <= '0;
            ram_wdata  <= '0;
            ram_wen    <= 1'b0;
            rd_data    <= '0;
            rd_valid   <= 1'b0;
            line_done  <= 1'b0;
            last_row   <= c_ROW_LAST;
            r_wr_col   <= '0;
            r_wr_row   <= '0;
            r_row_base <= '0;
`ifdef FRAME_CLEAR_EN
            r_clr_cnt  <= '0;
`endif
        end else begin
            rd_valid  <= 1'b0;
            line_done <= 1'b0;
            case (r_state)
`ifdef FRAME_CLEAR_EN
                c_ST_CLEAR: begin
                    // Leave only once the final address is actually on the
                    // RAM port, so busy covers the last clear write too.
                    if (ram_wen && (ram_addr == c_PIX_LAST)) begin
                        r_state <= c_ST_IDLE;
                        ram_wen <= 1'b0;
                    end else begin
                        ram_addr  <= r_clr_cnt;
                        ram_wdata <= 8'h00;
                        ram_wen   <= 1'b1;
                        r_clr_cnt <= r_clr_cnt + 17'd1;
                    end
                end
`endif
                c_ST_IDLE: begin
                    if (rd_req) begin
                        // Read wins over a simultaneous sample.
                        r_state  <= c_ST_RD_ADDR;
                        ram_addr <= rd_addr;
                        ram_wen  <= 1'b0;
                    end else if (s_valid) begin
                        ram_addr  <= r_row_base + r_wr_col;
                        ram_wdata <= s_data;
                        ram_wen   <= 1'b1;
                        if (r_wr_col == c_COL_LAST) begin
                            r_wr_col  <= '0;
                            line_done <= 1'b1;
                            last_row  <= r_wr_row;
                            if (r_wr_row == c_ROW_LAST) begin
                                r_wr_row   <= '0;
                                r_row_base <= '0;
                            end else begin
                                r_wr_row   <= r_wr_row + 8'd1;
                                r_row_base <= r_row_base + c_WIDTH;
                            end
                        end else begin
                            r_wr_col <= r_wr_col + 17'd1;
                        end
                    end else begin
                        ram_wen <= 1'b0;
                    end
                end
                c_ST_RD_ADDR: begin
                    // RAM samples the held address at the end of this cycle.
                    r_state <= c_ST_RD_HOLD;
                    ram_wen <= 1'b0;
                end
                c_ST_RD_HOLD: begin
                    rd_data  <= ram_rdata;
                    rd_valid <= 1'b1;
                    r_state  <= c_ST_IDLE;
                    ram_wen  <= 1'b0;
                end
                default: begin
                    r_state <= c_ST_IDLE;
                    ram_wen <= 1'b0;
                end
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_waterfall_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_waterfall_writer
//  Purpose  : Directed self-checking bench for waterfall_writer.  The RAM is
//             modelled as a registered read returning addr[7:0] ^ 8'hA5.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_waterfall_writer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  s_data = '0;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic        rd_req = 1'b0;
    logic [16:0] rd_addr = '0;
    logic        rd_ready;
    logic [7:0]  rd_data;
    logic        rd_valid;
    logic [16:0] ram_addr;
    logic [7:0]  ram_wdata;
    logic        ram_wen;
    logic [7:0]  ram_rdata = '0;
    logic        line_done;
    logic [7:0]  last_row;
    logic        busy;

    int checks   = 0;
    int failures = 0;

    waterfall_writer #(.WIDTH(320), .HEIGHT(240)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .rd_req    (rd_req),
        .rd_addr   (rd_addr),
        .rd_ready  (rd_ready),
        .rd_data   (rd_data),
        .rd_valid  (rd_valid),
        .ram_addr  (ram_addr),
        .ram_wdata (ram_wdata),
        .ram_wen   (ram_wen),
        .ram_rdata (ram_rdata),
        .line_done (line_done),
        .last_row  (last_row),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Registered-read RAM model.
    always @(posedge clk) ram_rdata <= ram_addr[7:0] ^ 8'hA5;

    initial begin
        #1_500_000;
        $display("FAIL watchdog: simulation time limit reached, actual=running required=finished");
        $fatal(1, "watchdog");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        tick();
        tick();
        checks++; if (ram_addr !== 17'd0)  begin failures++; $display("FAIL reset_ram_addr actual=%0d required=0", ram_addr); end
        checks++; if (ram_wdata !== 8'd0)  begin failures++; $display("FAIL reset_ram_wdata actual=%0h required=0", ram_wdata); end
        checks++; if (ram_wen !== 1'b0)    begin failures++; $display("FAIL reset_ram_wen actual=%b required=0", ram_wen); end
        checks++; if (rd_data !== 8'd0)    begin failures++; $display("FAIL reset_rd_data actual=%0h required=0", rd_data); end
        checks++; if (rd_valid !== 1'b0)   begin failures++; $display("FAIL reset_rd_valid actual=%b required=0", rd_valid); end
        checks++; if (line_done !== 1'b0)  begin failures++; $display("FAIL reset_line_done actual=%b required=0", line_done); end
        checks++; if (last_row !== 8'd239) begin failures++; $display("FAIL reset_last_row actual=%0d required=239", last_row); end
`ifdef FRAME_CLEAR_EN
        checks++; if (busy !== 1'b1)       begin failures++; $display("FAIL reset_busy actual=%b required=1", busy); end
        checks++; if (s_ready !== 1'b0)    begin failures++; $display("FAIL reset_s_ready actual=%b required=0", s_ready); end
        checks++; if (rd_ready !== 1'b0)   begin failures++; $display("FAIL reset_rd_ready actual=%b required=0", rd_ready); end
`else
        checks++; if (busy !== 1'b0)       begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (s_ready !== 1'b1)    begin failures++; $display("FAIL reset_s_ready actual=%b required=1", s_ready); end
        checks++; if (rd_ready !== 1'b1)   begin failures++; $display("FAIL reset_rd_ready actual=%b required=1", rd_ready); end
`endif
    endtask

`ifdef FRAME_CLEAR_EN
    task automatic test_frame_clear();
        int  writes = 0;
        bit  done = 1'b0;
        logic [16:0] prev_addr = '0;
        logic        prev_wen = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'h5A;
        reset_n = 1'b1;
        for (int cyc = 0; cyc < 80000 && !done; cyc++) begin
            tick();
            if (busy === 1'b1) begin
                checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL clear_s_ready cyc=%0d actual=%b required=0", cyc, s_ready); end
                if (ram_wen === 1'b1) begin
                    checks++; if (ram_addr !== 17'(writes) || ram_wdata !== 8'h00) begin
                        failures++; $display("FAIL clear_write addr=%0d data=%0h required addr=%0d data=0", ram_addr, ram_wdata, writes);
                    end
                    writes++;
                end
                prev_addr = ram_addr;
                prev_wen  = ram_wen;
            end else begin
                done = 1'b1;
            end
        end
        checks++; if (!done) begin failures++; $display("FAIL clear_timeout actual=busy_high required=busy_low"); end
        checks++; if (writes != 76800) begin failures++; $display("FAIL clear_count actual=%0d required=76800", writes); end
        checks++; if (prev_wen !== 1'b1 || prev_addr !== 17'd76799) begin
            failures++; $display("FAIL clear_last_before_idle actual addr=%0d wen=%b required addr=76799 wen=1", prev_addr, prev_wen);
        end
        checks++; if (s_ready !== 1'b1) begin failures++; $display("FAIL clear_idle_s_ready actual=%b required=1", s_ready); end
        s_valid = 1'b0;
    endtask
`endif

    task automatic test_row();
        reset_n = 1'b1;
        s_valid = 1'b1;
        for (int i = 0; i < 320; i++) begin
            s_data = 8'(i % 64);
            tick();
            checks++; if (ram_wen !== 1'b1 || ram_addr !== 17'(i) || ram_wdata !== 8'(i % 64)) begin
                failures++; $display("FAIL row_write i=%0d actual wen=%b addr=%0d data=%0h required wen=1 addr=%0d data=%0h",
                                     i, ram_wen, ram_addr, ram_wdata, i, i % 64);
            end
            checks++; if (line_done !== (i == 319)) begin
                failures++; $display("FAIL row_line_done i=%0d actual=%b required=%b", i, line_done, (i == 319));
            end
        end
        checks++; if (last_row !== 8'd0) begin failures++; $display("FAIL row_last_row actual=%0d required=0", last_row); end
        s_valid = 1'b0;
        tick();
        checks++; if (ram_wen !== 1'b0) begin failures++; $display("FAIL row_idle_wen actual=%b required=0", ram_wen); end
        checks++; if (line_done !== 1'b0) begin failures++; $display("FAIL row_line_done_pulse actual=%b required=0", line_done); end
    endtask

    task automatic test_read_priority();
        // Write position is now row 1, column 0 (address 320).
        rd_req  = 1'b1;
        rd_addr = 17'd321;
        s_valid = 1'b1;
        s_data  = 8'h77;
        #1;
        checks++; if (s_ready !== 1'b0) begin failures++; $display("FAIL rdpri_s_ready actual=%b required=0", s_ready); end
        checks++; if (rd_ready !== 1'b1) begin failures++; $display("FAIL rdpri_rd_ready actual=%b required=1", rd_ready); end
        tick();
        rd_req = 1'b0;
        #1;
        checks++; if (ram_addr !== 17'd321 || ram_wen !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rdpri_cyc1 actual addr=%0d wen=%b rv=%b required addr=321 wen=0 rv=0", ram_addr, ram_wen, rd_valid);
        end
        checks++; if (s_ready !== 1'b0 || rd_ready !== 1'b0) begin
            failures++; $display("FAIL rdpri_busy_ready actual s_ready=%b rd_ready=%b required 0 0", s_ready, rd_ready);
        end
        tick();
        checks++; if (ram_addr !== 17'd321 || ram_wen !== 1'b0 || rd_valid !== 1'b0) begin
            failures++; $display("FAIL rdpri_cyc2 actual addr=%0d wen=%b rv=%b required addr=321 wen=0 rv=0", ram_addr, ram_wen, rd_valid);
        end
        tick();
        checks++; if (rd_valid !== 1'b1 || rd_data !== 8'hE4) begin
            failures++; $display("FAIL rdpri_result actual rv=%b data=%0h required rv=1 data=e4", rd_valid, rd_data);
        end
        checks++; if (ram_wen !== 1'b0) begin failures++; $display("FAIL rdpri_no_write actual=%b required=0", ram_wen); end
        tick();
        checks++; if (ram_wen !== 1'b1 || ram_addr !== 17'd320 || ram_wdata !== 8'h77) begin
            failures++; $display("FAIL rdpri_sample_after actual wen=%b addr=%0d data=%0h required wen=1 addr=320 data=77", ram_wen, ram_addr, ram_wdata);
        end
        checks++; if (rd_valid !== 1'b0) begin failures++; $display("FAIL rdpri_rv_pulse actual=%b required=0", rd_valid); end
        s_valid = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid_read();
        int rv_seen = 0;
        rd_req  = 1'b1;
        rd_addr = 17'd5;
        tick();
        rd_req = 1'b0;
        tick();                 // now in RD_HOLD
        reset_n = 1'b0;
        #1;
        checks++; if (ram_addr !== 17'd0 || ram_wen !== 1'b0 || rd_valid !== 1'b0 || rd_data !== 8'd0) begin
            failures++; $display("FAIL midrd_async actual addr=%0d wen=%b rv=%b data=%0h required 0 0 0 0", ram_addr, ram_wen, rd_valid, rd_data);
        end
        checks++; if (last_row !== 8'd239 || line_done !== 1'b0) begin
            failures++; $display("FAIL midrd_async_row actual last_row=%0d ld=%b required 239 0", last_row, line_done);
        end
        tick();
        tick();
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (rd_valid === 1'b1) rv_seen++;
        end
        checks++; if (rv_seen != 0) begin failures++; $display("FAIL midrd_no_rd_valid actual=%0d required=0", rv_seen); end
    endtask

    task automatic test_frame_wrap();
        int ld_count = 0;
        s_valid = 1'b1;
        for (int i = 0; i < 76805; i++) begin
            s_data = 8'(i);
            tick();
            checks++; if (ram_wen !== 1'b1 || ram_addr !== 17'(i % 76800) || ram_wdata !== 8'(i)) begin
                failures++; $display("FAIL wrap_write i=%0d actual wen=%b addr=%0d data=%0h required wen=1 addr=%0d data=%0h",
                                     i, ram_wen, ram_addr, ram_wdata, i % 76800, 8'(i));
            end
            checks++; if (line_done !== ((i % 320) == 319)) begin
                failures++; $display("FAIL wrap_line_done i=%0d actual=%b required=%b", i, line_done, ((i % 320) == 319));
            end
            if (line_done === 1'b1) begin
                ld_count++;
                checks++; if (last_row !== 8'((i / 320) % 240)) begin
                    failures++; $display("FAIL wrap_last_row i=%0d actual=%0d required=%0d", i, last_row, (i / 320) % 240);
                end
            end
        end
        checks++; if (ld_count != 240) begin failures++; $display("FAIL wrap_line_count actual=%0d required=240", ld_count); end
        checks++; if (last_row !== 8'd239) begin failures++; $display("FAIL wrap_last_row_end actual=%0d required=239", last_row); end
        s_valid = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
`ifdef FRAME_CLEAR_EN
        test_frame_clear();
`else
        test_row();
        test_read_priority();
        test_reset_mid_read();
        test_frame_wrap();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
